// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Front-panel time-setting controller for an mm:ss clock. Debounces the
//   mode and increment buttons, runs a RUN / SET_MIN / SET_SEC edit
//   sequence on a BCD copy of the live time, hands the edited digits back
//   to the time core with a one-cycle load strobe, and blinks the field
//   being edited through a per-digit blank mask.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a button level is accepted
//   BLINK_CYCLES     half-period of the edit-field blink, in clk cycles
//
// Ports
//   clk                       system clock
//   reset                     synchronous, active-high reset
//   btn_mode, btn_inc         raw asynchronous active-high buttons
//   cur_mX/mU/sX/sU   [3:0]   live BCD time from the core
//   set_mX/mU/sX/sU   [3:0]   edit registers (always driven)
//   load                      one-cycle strobe: core copies set_*
//   run_en                    core count enable, high only in RUN
//   blank_mask        [3:0]   per-digit blank {mX, mU, sX, sU}
//
// Build option
//   AUTO_REPEAT_EN   when defined, holding btn_inc in an edit state repeats
//                    the increment (first after 2*BLINK_CYCLES, then every
//                    BLINK_CYCLES). Undefined: one increment per press.
//
// FSM states
//   state   | meaning
//   RUN     | core counting; mode press captures cur_* and starts editing
//   SET_MIN | editing minutes; inc bumps minutes, mode goes to SET_SEC
//   SET_SEC | editing seconds; inc bumps seconds, mode loads and returns

module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_mX,
    input  logic [3:0] cur_mU,
    input  logic [3:0] cur_sX,
    input  logic [3:0] cur_sU,
    output logic [3:0] set_mX,
    output logic [3:0] set_mU,
    output logic [3:0] set_sX,
    output logic [3:0] set_sU,
    output logic       load,
    output logic       run_en,
    output logic [3:0] blank_mask
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {RUN, SET_MIN, SET_SEC} state_t;

    state_t      state, state_nx;
    logic [15:0] edit, edit_nx;
    logic        load_q, load_nx;
    logic        phase_clr;

    // ---------------- button synchronizers and debouncers ----------------
    // bit 0 = mode, bit 1 = inc
    logic [1:0]    sync1, sync2, db, db_q;
    logic [DW-1:0] db_cnt [2];
    logic          press_mode, press_inc, inc_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_q   <= '0;
            db_cnt <= '{default: '0};
        end else begin
            sync1 <= {btn_inc, btn_mode};
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press_mode = db[0] & ~db_q[0];
    assign press_inc  = db[1] & ~db_q[1];

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(2 * BLINK_CYCLES + 1);
    logic [RW-1:0] rpt_cnt;
    logic          rpt_first, rpt_fire, editing;

    assign editing  = (state != RUN);
    assign rpt_fire = db[1] && editing && !press_inc &&
                      (rpt_first ? (rpt_cnt == RW'(2 * BLINK_CYCLES - 1))
                                 : (rpt_cnt == RW'(BLINK_CYCLES - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (press_inc) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (db[1] && editing) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end else begin
            rpt_cnt <= '0;
        end
    end

    assign inc_pulse = press_inc | rpt_fire;
`else
    assign inc_pulse = press_inc;
`endif

    // ---------------- BCD helpers ----------------
    // Two-digit 00..59 increment; 59 wraps to 00 with no carry out.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {((v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1), 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [3:0] san_x(input logic [3:0] d);
        return (d > 4'd5) ? 4'd0 : d;
    endfunction

    function automatic logic [3:0] san_u(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            edit   <= '0;
            load_q <= 1'b0;
        end else begin
            state  <= state_nx;
            edit   <= edit_nx;
            load_q <= load_nx;
        end
    end

    // Mode is tested first in every state, so a coincident inc is dropped.
    always_comb begin
        state_nx  = state;
        edit_nx   = edit;
        load_nx   = 1'b0;
        phase_clr = 1'b0;
        case (state)
            RUN: begin
                if (press_mode) begin
                    edit_nx   = {san_x(cur_mX), san_u(cur_mU),
                                 san_x(cur_sX), san_u(cur_sU)};
                    state_nx  = SET_MIN;
                    phase_clr = 1'b1;
                end
            end
            SET_MIN: begin
                if (press_mode) begin
                    state_nx  = SET_SEC;
                    phase_clr = 1'b1;
                end else if (inc_pulse) begin
                    edit_nx[15:8] = bcd_inc(edit[15:8]);
                    phase_clr     = 1'b1;
                end
            end
            SET_SEC: begin
                if (press_mode) begin
                    state_nx = RUN;
                    load_nx  = 1'b1;
                end else if (inc_pulse) begin
                    edit_nx[7:0] = bcd_inc(edit[7:0]);
                    phase_clr    = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // ---------------- blink phase ----------------
    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge clk) begin
        if (reset || phase_clr) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        blank_mask = 4'b0000;
        case (state)
            SET_MIN: blank_mask = {phase, phase, 2'b00};
            SET_SEC: blank_mask = {2'b00, phase, phase};
            default: blank_mask = 4'b0000;
        endcase
    end

    assign {set_mX, set_mU, set_sX, set_sU} = edit;
    assign load   = load_q;
    assign run_en = (state == RUN);

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_mX = '0, cur_mU = '0, cur_sX = '0, cur_sU = '0;
    logic [3:0] set_mX, set_mU, set_sX, set_sU;
    logic       load, run_en;
    logic [3:0] blank_mask;
    logic [15:0] setv;

    int checks = 0;
    int failures = 0;

    assign setv = {set_mX, set_mU, set_sX, set_sU};

    always #5 clk = ~clk;

    time_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_mX(cur_mX), .cur_mU(cur_mU), .cur_sX(cur_sX), .cur_sU(cur_sU),
        .set_mX(set_mX), .set_mU(set_mU), .set_sX(set_sX), .set_sU(set_sU),
        .load(load), .run_en(run_en), .blank_mask(blank_mask)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold a button long enough to debounce, then release and let release debounce.
    task automatic press(input bit inc);
        if (inc) btn_inc = 1'b1; else btn_mode = 1'b1;
        tick(12);
        btn_inc  = 1'b0;
        btn_mode = 1'b0;
        tick(12);
    endtask

    task automatic set_cur(input logic [15:0] v);
        {cur_mX, cur_mU, cur_sX, cur_sU} = v;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (run_en !== 1'b1) begin $display("FAIL reset_run_en: got %b want 1", run_en); failures++; end
        checks++;
        if (load !== 1'b0) begin $display("FAIL reset_load: got %b want 0", load); failures++; end
        checks++;
        if (blank_mask !== 4'b0000) begin $display("FAIL reset_blank: got %b want 0000", blank_mask); failures++; end
        checks++;
        if (setv !== 16'h0000) begin $display("FAIL reset_set: got %h want 0000", setv); failures++; end
    endtask

    task automatic test_glitch;
        int low_cycles;
        set_cur(16'h1234);
        btn_mode = 1'b1;
        tick(3);
        btn_mode = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (run_en !== 1'b1) low_cycles++;
        end
        checks++;
        if (low_cycles !== 0) begin $display("FAIL glitch_run_en: run_en low %0d cycles want 0", low_cycles); failures++; end
        checks++;
        if (setv !== 16'h0000) begin $display("FAIL glitch_no_capture: got %h want 0000", setv); failures++; end
    endtask

    task automatic test_capture_blink;
        bit found;
        logic [3:0] exp_b;
        set_cur(16'h1234);
        btn_mode = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (run_en === 1'b0) begin found = 1; break; end
        end
        checks++;
        if (!found) begin $display("FAIL capture_enter: run_en never fell within 20 cycles"); failures++; end
        checks++;
        if (setv !== 16'h1234) begin $display("FAIL capture_1234: got %h want 1234", setv); failures++; end
        // first sample is the cycle just after the entering press pulse
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) @(negedge clk);
            exp_b = (k >= 9 && k <= 16) ? 4'b1100 : 4'b0000;
            checks++;
            if (blank_mask !== exp_b) begin
                $display("FAIL blink_k%0d: got %b want %b", k, blank_mask, exp_b); failures++;
            end
        end
        btn_mode = 1'b0;
        tick(12);
        press(0);
        press(0);
        checks++;
        if (run_en !== 1'b1) begin $display("FAIL capture_return_run: got %b want 1", run_en); failures++; end
        set_cur(16'h5907);
        press(0);
        checks++;
        if (setv !== 16'h5907) begin $display("FAIL capture_5907: got %h want 5907", setv); failures++; end
        press(1);
        checks++;
        if (setv !== 16'h0007) begin $display("FAIL min_wrap: got %h want 0007", setv); failures++; end
        press(0);
        press(0);
    endtask

    task automatic test_sanitize;
        set_cur(16'h736C);
        press(0);
        checks++;
        if (setv !== 16'h0300) begin $display("FAIL sanitize: got %h want 0300", setv); failures++; end
        press(0);
        press(0);
    endtask

    task automatic test_full_sequence;
        int nl;
        logic [15:0] set_at;
        logic run_at;
        set_cur(16'h1258);
        press(0);
        checks++;
        if (setv !== 16'h1258) begin $display("FAIL seq_capture: got %h want 1258", setv); failures++; end
        press(1);
        checks++;
        if (setv !== 16'h1358) begin $display("FAIL seq_min_inc: got %h want 1358", setv); failures++; end
        press(0);
        press(1);
        checks++;
        if (setv !== 16'h1359) begin $display("FAIL seq_sec_inc: got %h want 1359", setv); failures++; end
        press(1);
        checks++;
        if (setv !== 16'h1300) begin $display("FAIL seq_sec_wrap: got %h want 1300", setv); failures++; end
        btn_mode = 1'b1;
        nl = 0; set_at = '0; run_at = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 12) btn_mode = 1'b0;
            if (load === 1'b1) begin nl++; set_at = setv; run_at = run_en; end
        end
        checks++;
        if (nl !== 1) begin $display("FAIL seq_load_count: got %0d want 1", nl); failures++; end
        checks++;
        if (set_at !== 16'h1300) begin $display("FAIL seq_load_set: got %h want 1300", set_at); failures++; end
        checks++;
        if (run_at !== 1'b1) begin $display("FAIL seq_load_run_en: got %b want 1", run_at); failures++; end
        checks++;
        if (setv !== 16'h1300) begin $display("FAIL seq_set_stable: got %h want 1300", setv); failures++; end
    endtask

    task automatic test_simultaneous;
        int nl;
        logic [15:0] set_at;
        set_cur(16'h0530);
        press(0);
        press(0);
        checks++;
        if (run_en !== 1'b0) begin $display("FAIL simul_in_set: run_en got %b want 0", run_en); failures++; end
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        nl = 0; set_at = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 12) begin btn_mode = 1'b0; btn_inc = 1'b0; end
            if (load === 1'b1) begin nl++; set_at = setv; end
        end
        checks++;
        if (nl !== 1) begin $display("FAIL simul_load_count: got %0d want 1", nl); failures++; end
        checks++;
        if (set_at !== 16'h0530) begin $display("FAIL simul_load_set: got %h want 0530", set_at); failures++; end
        checks++;
        if (run_en !== 1'b1) begin $display("FAIL simul_run_en: got %b want 1", run_en); failures++; end
    endtask

    task automatic test_reset_in_set_sec;
        int nl;
        set_cur(16'h1234);
        press(0);
        press(0);
        checks++;
        if (blank_mask[3:2] !== 2'b00) begin $display("FAIL setsec_min_visible: got %b want 00xx", blank_mask); failures++; end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        nl = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (load === 1'b1) nl++;
        end
        checks++;
        if (nl !== 0) begin $display("FAIL rst_setsec_load: got %0d pulses want 0", nl); failures++; end
        checks++;
        if (run_en !== 1'b1) begin $display("FAIL rst_setsec_run_en: got %b want 1", run_en); failures++; end
        checks++;
        if (setv !== 16'h0000) begin $display("FAIL rst_setsec_set: got %h want 0000", setv); failures++; end
        checks++;
        if (blank_mask !== 4'b0000) begin $display("FAIL rst_setsec_blank: got %b want 0000", blank_mask); failures++; end
    endtask

    task automatic test_inc_hold;
        logic [15:0] exp_v;
`ifdef AUTO_REPEAT_EN
        exp_v = 16'h0005;
`else
        exp_v = 16'h0001;
`endif
        set_cur(16'h0000);
        press(0);
        press(0);
        btn_inc = 1'b1;
        tick(44);
        btn_inc = 1'b0;
        tick(12);
        checks++;
        if (setv !== exp_v) begin $display("FAIL inc_hold: got %h want %h", setv, exp_v); failures++; end
        press(0);
        checks++;
        if (run_en !== 1'b1) begin $display("FAIL inc_hold_exit: run_en got %b want 1", run_en); failures++; end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_capture_blink();
        test_sanitize();
        test_full_sequence();
        test_simultaneous();
        test_reset_in_set_sec();
        test_inc_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
